// File: rtl/sm_eth_pkt_pkg.sv
// Shared types and helpers for the egress packet sink.
// Holds the FSM encoding, LFSR constants and saturating arithmetic.
package sm_eth_pkt_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_IN_PKT
  } sink_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Widths up to 48 bits fit, so the 64-bit sum cannot overflow.
  function automatic logic [63:0] sat_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input int unsigned w
  );
    logic [63:0] sum;
    logic [63:0] max;
    max = (64'd1 << w) - 64'd1;
    sum = a + b;
    sat_add = (sum > max) ? max : sum;
  endfunction

endpackage

// File: rtl/sm_eth_bp_lfsr.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random backpressure.
// Loads the seed on reset and steps only while enabled.
module sm_eth_bp_lfsr
  import sm_eth_pkt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] lfsr
);

  logic fb;

  assign fb = ^(lfsr & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= seed;
    end else if (en) begin
      lfsr <= {lfsr[14:0], fb};
    end
  end

endmodule

// File: rtl/sm_eth_egress_pkt_sink.sv
// Avalon-ST egress packet sink: backpressure, SOP/EOP framing checks
// and saturating per-port packet, byte and error statistics.
module sm_eth_egress_pkt_sink
  import sm_eth_pkt_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int EMPTY_W    = 3,
  parameter int CNT_W      = 32,
  parameter int BYTE_CNT_W = 48,
  parameter int LEN_W      = 16
) (
  input  logic                  egress_clk,
  input  logic                  egress_rst,
  input  logic [DATA_W-1:0]     egress_data,
  input  logic                  egress_valid,
  output logic                  egress_ready,
  input  logic                  egress_sop,
  input  logic                  egress_eop,
  input  logic [EMPTY_W-1:0]    egress_empty,
  input  logic                  egress_error,
  input  logic                  bp_en,
  input  logic [3:0]            bp_thresh,
  input  logic                  stat_clear,
  output logic [CNT_W-1:0]      pkt_cnt,
  output logic [CNT_W-1:0]      pkt_err_cnt,
  output logic [BYTE_CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0]      missing_sop_cnt,
  output logic [CNT_W-1:0]      missing_eop_cnt,
  output logic [LEN_W-1:0]      last_len,
  output logic                  last_len_vld
);

  localparam int BEAT_B = DATA_W / 8;

  sink_state_t      state;
  logic [LEN_W-1:0] len_acc;
  logic [15:0]      lfsr;
  logic             xfer;
  logic             done;
  logic             drop_sop;
  logic             drop_eop;
  logic [LEN_W-1:0] base;
  logic [LEN_W:0]   len_sum;
  logic [LEN_W-1:0] pkt_len;
  logic [LEN_W:0]   acc_sum;
  logic [LEN_W-1:0] acc_next;
  logic             unused_ok;

  assign unused_ok = ^{egress_data, lfsr[15:4]};

  sm_eth_bp_lfsr u_lfsr (
    .clk  (egress_clk),
    .rst  (egress_rst),
    .en   (bp_en),
    .seed (LFSR_SEED),
    .lfsr (lfsr)
  );

  assign xfer = egress_valid & egress_ready;

  always_comb begin
    done     = 1'b0;
    drop_sop = 1'b0;
    drop_eop = 1'b0;
    base     = '0;
    if (xfer) begin
      unique case (state)
        ST_IDLE: begin
          drop_sop = !egress_sop;
          done     = egress_sop & egress_eop;
        end
        ST_IN_PKT: begin
          drop_eop = egress_sop;
          done     = egress_eop;
          base     = egress_sop ? '0 : len_acc;
        end
        default: ;
      endcase
    end
  end

  // A SOP always restarts the length, even when it replaces an open packet.
  always_comb begin
    len_sum  = (LEN_W+1)'(base) + (LEN_W+1)'(BEAT_B)
             - (LEN_W+1)'(egress_empty);
    pkt_len  = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
    acc_sum  = (LEN_W+1)'(len_acc) + (LEN_W+1)'(BEAT_B);
    acc_next = acc_sum[LEN_W] ? '1 : acc_sum[LEN_W-1:0];
  end

  always_ff @(posedge egress_clk) begin
    if (egress_rst) begin
      egress_ready <= 1'b0;
    end else if (bp_en) begin
      egress_ready <= !(lfsr[3:0] < bp_thresh);
    end else begin
      egress_ready <= 1'b1;
    end
  end

  always_ff @(posedge egress_clk) begin
    if (egress_rst) begin
      state   <= ST_IDLE;
      len_acc <= '0;
    end else if (xfer) begin
      unique case (state)
        ST_IDLE: begin
          if (egress_sop && !egress_eop) begin
            state   <= ST_IN_PKT;
            len_acc <= LEN_W'(BEAT_B);
          end
        end
        ST_IN_PKT: begin
          if (egress_sop) begin
            if (egress_eop) begin
              state <= ST_IDLE;
            end else begin
              len_acc <= LEN_W'(BEAT_B);
            end
          end else if (egress_eop) begin
            state <= ST_IDLE;
          end else begin
            len_acc <= acc_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge egress_clk) begin
    if (egress_rst) begin
      pkt_cnt         <= '0;
      pkt_err_cnt     <= '0;
      byte_cnt        <= '0;
      missing_sop_cnt <= '0;
      missing_eop_cnt <= '0;
      last_len        <= '0;
      last_len_vld    <= 1'b0;
    end else begin
      last_len_vld <= done;
      if (done) begin
        last_len <= pkt_len;
      end
      if (stat_clear) begin
        pkt_cnt         <= '0;
        pkt_err_cnt     <= '0;
        byte_cnt        <= '0;
        missing_sop_cnt <= '0;
        missing_eop_cnt <= '0;
      end else begin
        if (done) begin
          pkt_cnt  <= CNT_W'(sat_add(64'(pkt_cnt), 64'd1, CNT_W));
          byte_cnt <= BYTE_CNT_W'(sat_add(64'(byte_cnt),
                                          64'(pkt_len), BYTE_CNT_W));
          if (egress_error) begin
            pkt_err_cnt <= CNT_W'(sat_add(64'(pkt_err_cnt),
                                          64'd1, CNT_W));
          end
        end
        if (drop_sop) begin
          missing_sop_cnt <= CNT_W'(sat_add(64'(missing_sop_cnt),
                                            64'd1, CNT_W));
        end
        if (drop_eop) begin
          missing_eop_cnt <= CNT_W'(sat_add(64'(missing_eop_cnt),
                                            64'd1, CNT_W));
        end
      end
    end
  end

endmodule

// File: tb/tb_sm_eth_egress_pkt_sink.sv
// Randomized self-checking bench for the egress packet sink.
// A beat-counting packet model predicts counters and last length.
module tb_sm_eth_egress_pkt_sink;

  logic        clk;
  logic        egress_rst;
  logic [63:0] egress_data;
  logic        egress_valid;
  logic        egress_ready;
  logic        egress_sop;
  logic        egress_eop;
  logic [2:0]  egress_empty;
  logic        egress_error;
  logic        bp_en;
  logic [3:0]  bp_thresh;
  logic        stat_clear;
  logic [31:0] pkt_cnt;
  logic [31:0] pkt_err_cnt;
  logic [47:0] byte_cnt;
  logic [31:0] missing_sop_cnt;
  logic [31:0] missing_eop_cnt;
  logic [15:0] last_len;
  logic        last_len_vld;

  int checks = 0;
  int errors = 0;

  longint m_pkt, m_err, m_bytes, m_msop, m_meop;
  int     m_last;
  bit     m_open;
  int     m_beats;
  int     rdy_hi, rdy_lo;

  sm_eth_egress_pkt_sink dut (
    .egress_clk      (clk),
    .egress_rst      (egress_rst),
    .egress_data     (egress_data),
    .egress_valid    (egress_valid),
    .egress_ready    (egress_ready),
    .egress_sop      (egress_sop),
    .egress_eop      (egress_eop),
    .egress_empty    (egress_empty),
    .egress_error    (egress_error),
    .bp_en           (bp_en),
    .bp_thresh       (bp_thresh),
    .stat_clear      (stat_clear),
    .pkt_cnt         (pkt_cnt),
    .pkt_err_cnt     (pkt_err_cnt),
    .byte_cnt        (byte_cnt),
    .missing_sop_cnt (missing_sop_cnt),
    .missing_eop_cnt (missing_eop_cnt),
    .last_len        (last_len),
    .last_len_vld    (last_len_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pkt = 0; m_err = 0; m_bytes = 0; m_msop = 0; m_meop = 0;
    m_last = 0; m_open = 0; m_beats = 0;
  endtask

  task automatic model_complete(input int nbeats, input int empty,
                                input bit err);
    int len;
    len = 8 * nbeats - empty;
    m_pkt++;
    m_bytes += len;
    if (err) m_err++;
    m_last = len;
  endtask

  task automatic model_beat(input bit sop, input bit eop,
                            input int empty, input bit err);
    if (!m_open) begin
      if (!sop) m_msop++;
      else if (eop) model_complete(1, empty, err);
      else begin m_open = 1; m_beats = 1; end
    end else if (sop) begin
      m_meop++;
      if (eop) begin m_open = 0; model_complete(1, empty, err); end
      else m_beats = 1;
    end else begin
      m_beats++;
      if (eop) begin m_open = 0; model_complete(m_beats, empty, err); end
    end
  endtask

  task automatic send_beat(input bit sop, input bit eop,
                           input logic [2:0] empty, input bit err);
    int w;
    w = 0;
    @(negedge clk);
    egress_valid = 1'b1;
    egress_sop   = sop;
    egress_eop   = eop;
    egress_empty = empty;
    egress_error = err;
    egress_data  = {$urandom, $urandom};
    while (!egress_ready) begin
      rdy_lo++;
      w++;
      if (w > 500) begin
        $display("FAIL ready_timeout: ready=%0b required=1", egress_ready);
        $fatal(1, "ready never returned");
      end
      @(negedge clk);
    end
    rdy_hi++;
    model_beat(sop, eop, int'(empty), err);
  endtask

  task automatic idle();
    @(negedge clk);
    egress_valid = 1'b0;
    egress_sop   = 1'b0;
    egress_eop   = 1'b0;
    egress_error = 1'b0;
  endtask

  task automatic clear_stats();
    @(negedge clk);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    m_pkt = 0; m_err = 0; m_bytes = 0; m_msop = 0; m_meop = 0;
  endtask

  task automatic test_reset();
    egress_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (egress_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %0b exp 0", egress_ready);
    end
    checks++;
    if ({pkt_cnt, pkt_err_cnt, missing_sop_cnt, missing_eop_cnt}
        !== 128'd0 || byte_cnt !== 48'd0) begin
      errors++;
      $display("FAIL reset_cnt: pkt=%0d err=%0d bytes=%0d exp 0",
               pkt_cnt, pkt_err_cnt, byte_cnt);
    end
    checks++;
    if (last_len !== 16'd0 || last_len_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_len: len=%0d vld=%0b exp 0/0",
               last_len, last_len_vld);
    end
    egress_rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (egress_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_rst: got %0b exp 1", egress_ready);
    end
  endtask

  task automatic test_basic();
    bp_en = 1'b0;
    rdy_lo = 0;
    for (int p = 0; p < 10; p++)
      for (int b = 0; b < 4; b++)
        send_beat(b == 0, b == 3, (b == 3) ? 3'd3 : 3'd0, 1'b0);
    idle();
    checks++;
    if (pkt_cnt !== 32'd10) begin
      errors++;
      $display("FAIL basic_pkt: got %0d exp 10", pkt_cnt);
    end
    checks++;
    if (byte_cnt !== 48'd290) begin
      errors++;
      $display("FAIL basic_bytes: got %0d exp 290", byte_cnt);
    end
    checks++;
    if (last_len !== 16'd29) begin
      errors++;
      $display("FAIL basic_last_len: got %0d exp 29", last_len);
    end
    checks++;
    if (rdy_lo != 0) begin
      errors++;
      $display("FAIL basic_ready: low %0d cycles exp 0", rdy_lo);
    end
  endtask

  task automatic test_single_err();
    clear_stats();
    send_beat(1'b1, 1'b1, 3'd0, 1'b1);
    idle();
    checks++;
    if (pkt_cnt !== 32'd1 || pkt_err_cnt !== 32'd1) begin
      errors++;
      $display("FAIL single_cnt: pkt=%0d err=%0d exp 1/1",
               pkt_cnt, pkt_err_cnt);
    end
    checks++;
    if (last_len !== 16'd8 || last_len_vld !== 1'b1) begin
      errors++;
      $display("FAIL single_len: len=%0d vld=%0b exp 8/1",
               last_len, last_len_vld);
    end
    @(negedge clk);
    checks++;
    if (last_len_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_vld_pulse: got %0b exp 0", last_len_vld);
    end
  endtask

  task automatic test_framing();
    clear_stats();
    send_beat(1'b0, 1'b1, 3'd0, 1'b0);
    send_beat(1'b1, 1'b0, 3'd0, 1'b0);
    send_beat(1'b0, 1'b0, 3'd0, 1'b1);
    send_beat(1'b1, 1'b0, 3'd0, 1'b0);
    send_beat(1'b0, 1'b1, 3'd2, 1'b0);
    idle();
    checks++;
    if (missing_sop_cnt !== 32'd1 || missing_eop_cnt !== 32'd1) begin
      errors++;
      $display("FAIL framing_missing: sop=%0d eop=%0d exp 1/1",
               missing_sop_cnt, missing_eop_cnt);
    end
    checks++;
    if (pkt_cnt !== 32'd1 || byte_cnt !== 48'd14 || last_len !== 16'd14)
    begin
      errors++;
      $display("FAIL framing_pkt: pkt=%0d bytes=%0d len=%0d exp 1/14/14",
               pkt_cnt, byte_cnt, last_len);
    end
  endtask

  task automatic test_backpressure();
    bit   q_sop[$], q_eop[$], q_err[$];
    int   q_emp[$];
    longint r_pkt, r_err, r_bytes, r_msop, r_meop;
    int   nb, duty;
    while (q_sop.size() < 1000) begin
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 19) == 0) begin
          q_sop.push_back(1'($urandom));
          q_eop.push_back(1'($urandom));
        end else begin
          q_sop.push_back(b == 0);
          q_eop.push_back(b == nb - 1);
        end
        q_emp.push_back($urandom_range(0, 7));
        q_err.push_back(1'($urandom));
      end
    end
    q_sop.push_back(1'b1); q_eop.push_back(1'b1);
    q_emp.push_back(0);    q_err.push_back(1'b0);

    clear_stats();
    bp_en = 1'b1;
    bp_thresh = 4'd8;
    rdy_hi = 0; rdy_lo = 0;
    foreach (q_sop[i]) send_beat(q_sop[i], q_eop[i], 3'(q_emp[i]), q_err[i]);
    idle();
    duty = (rdy_hi * 100) / (rdy_hi + rdy_lo);
    checks++;
    if (duty < 30 || duty > 70) begin
      errors++;
      $display("FAIL bp_duty: got %0d%% exp 30..70%%", duty);
    end
    checks++;
    if (pkt_cnt !== 32'(m_pkt) || pkt_err_cnt !== 32'(m_err) ||
        byte_cnt !== 48'(m_bytes)) begin
      errors++;
      $display("FAIL bp_counts: pkt=%0d/%0d err=%0d/%0d bytes=%0d/%0d",
               pkt_cnt, m_pkt, pkt_err_cnt, m_err, byte_cnt, m_bytes);
    end
    checks++;
    if (missing_sop_cnt !== 32'(m_msop) || missing_eop_cnt !== 32'(m_meop))
    begin
      errors++;
      $display("FAIL bp_missing: sop=%0d/%0d eop=%0d/%0d",
               missing_sop_cnt, m_msop, missing_eop_cnt, m_meop);
    end
    r_pkt = m_pkt; r_err = m_err; r_bytes = m_bytes;
    r_msop = m_msop; r_meop = m_meop;

    bp_en = 1'b0;
    clear_stats();
    rdy_lo = 0;
    foreach (q_sop[i]) send_beat(q_sop[i], q_eop[i], 3'(q_emp[i]), q_err[i]);
    idle();
    checks++;
    if (pkt_cnt !== 32'(r_pkt) || pkt_err_cnt !== 32'(r_err) ||
        byte_cnt !== 48'(r_bytes) || missing_sop_cnt !== 32'(r_msop) ||
        missing_eop_cnt !== 32'(r_meop)) begin
      errors++;
      $display("FAIL bp_replay: pkt=%0d/%0d bytes=%0d/%0d",
               pkt_cnt, r_pkt, byte_cnt, r_bytes);
    end
    checks++;
    if (rdy_lo != 0) begin
      errors++;
      $display("FAIL replay_ready: low %0d cycles exp 0", rdy_lo);
    end
  endtask

  task automatic test_stat_clear();
    logic [2:0] e;
    e = 3'($urandom_range(0, 7));
    clear_stats();
    send_beat(1'b1, 1'b0, 3'd0, 1'b0);
    stat_clear = 1'b1;
    send_beat(1'b0, 1'b1, e, 1'b1);
    idle();
    stat_clear = 1'b0;
    m_pkt = 0; m_err = 0; m_bytes = 0; m_msop = 0; m_meop = 0;
    checks++;
    if (pkt_cnt !== 32'd0 || pkt_err_cnt !== 32'd0 || byte_cnt !== 48'd0)
    begin
      errors++;
      $display("FAIL clear_cnt: pkt=%0d err=%0d bytes=%0d exp 0",
               pkt_cnt, pkt_err_cnt, byte_cnt);
    end
    checks++;
    if (last_len !== 16'(m_last) || last_len_vld !== 1'b1) begin
      errors++;
      $display("FAIL clear_len: len=%0d vld=%0b exp %0d/1",
               last_len, last_len_vld, m_last);
    end
  endtask

  task automatic test_rst_mid();
    logic [2:0] e;
    send_beat(1'b1, 1'b0, 3'd0, 1'b0);
    send_beat(1'b0, 1'b0, 3'd0, 1'b0);
    idle();
    egress_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (egress_ready !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_ready: cycle %0d got %0b exp 0",
                 i, egress_ready);
      end
    end
    egress_rst = 1'b0;
    model_reset();
    e = 3'($urandom_range(0, 7));
    send_beat(1'b1, 1'b0, 3'd0, 1'b0);
    send_beat(1'b0, 1'b0, 3'd0, 1'b0);
    send_beat(1'b0, 1'b1, e, 1'b0);
    idle();
    checks++;
    if (pkt_cnt !== 32'd1 || missing_eop_cnt !== 32'd0 ||
        missing_sop_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_cnt: pkt=%0d meop=%0d msop=%0d exp 1/0/0",
               pkt_cnt, missing_eop_cnt, missing_sop_cnt);
    end
    checks++;
    if (byte_cnt !== 48'(m_bytes) || last_len !== 16'(m_last)) begin
      errors++;
      $display("FAIL rst_mid_len: bytes=%0d len=%0d exp %0d/%0d",
               byte_cnt, last_len, m_bytes, m_last);
    end
  endtask

  initial begin
    egress_rst   = 1'b1;
    egress_data  = '0;
    egress_valid = 1'b0;
    egress_sop   = 1'b0;
    egress_eop   = 1'b0;
    egress_empty = '0;
    egress_error = 1'b0;
    bp_en        = 1'b0;
    bp_thresh    = 4'd0;
    stat_clear   = 1'b0;
    rdy_hi = 0;
    rdy_lo = 0;
    model_reset();
    test_reset();
    test_basic();
    test_single_err();
    test_framing();
    test_backpressure();
    test_stat_clear();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
